// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data_memory.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds all of
// them stable until the cycle in which gntN=1; the access is performed in that
// cycle (a write commits at its closing edge). A read returns rdataN with a
// one-cycle rvalidN strobe in the following cycle. There is no backpressure
// on the return path.
interface dmem_arbiter_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
);
    localparam int RUN_W = $clog2(MAX_BURST + 1);

    // Requester side
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid0;
    logic              rvalid1;

    // Memory side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter state, exported for observation
    logic              dbg_last;
    logic              dbg_busy_prev;
    logic [RUN_W-1:0]  dbg_run_len;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output dbg_last, dbg_busy_prev, dbg_run_len
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  dbg_last, dbg_busy_prev, dbg_run_len
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data_memory.
// Zero-latency grant, bounded burst under contention, registered read return.
// The interface instance must use the same parameter values as this module.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,   // synchronous, active low
    dmem_arbiter_if.slave  bus
);
    localparam int RUN_W = $clog2(MAX_BURST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BURST);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    // Arbitration state
    logic             r_last;
    logic             r_busy_prev;
    logic [RUN_W-1:0] r_run_len;

    logic             w_last_nxt;
    logic             w_busy_nxt;
    logic [RUN_W-1:0] w_run_nxt;

    // Grant and memory command
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    logic              w_gnt_port;
    logic              w_mem_read;
    logic              w_mem_write;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // Read return
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    assign w_any_gnt  = w_gnt0 | w_gnt1;
    assign w_gnt_port = w_gnt1;

    // State register: last winner, grant-last-cycle flag and run length
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last      <= 1'b1;
            r_busy_prev <= 1'b0;
            r_run_len   <= '0;
        end else begin
            r_last      <= w_last_nxt;
            r_busy_prev <= w_busy_nxt;
            r_run_len   <= w_run_nxt;
        end
    end

    // Next state: extend the run when the same port wins back to back
    always_comb begin
        w_last_nxt = r_last;
        w_busy_nxt = 1'b0;
        w_run_nxt  = '0;
        if (w_any_gnt) begin
            w_busy_nxt = 1'b1;
            w_last_nxt = w_gnt_port;
            if ((w_gnt_port == r_last) && r_busy_prev) begin
                w_run_nxt = (r_run_len >= RUN_MAX) ? r_run_len : r_run_len + RUN_ONE;
            end else begin
                w_run_nxt = RUN_ONE;
            end
        end
    end

    // Grant select: a lone requester always wins; a tie stays with the
    // current owner only while its run is below the burst limit
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            if (bus.req0 && !bus.req1) begin
                w_gnt0 = 1'b1;
            end else if (!bus.req0 && bus.req1) begin
                w_gnt1 = 1'b1;
            end else if (bus.req0 && bus.req1) begin
                if (r_busy_prev && (r_run_len < RUN_MAX)) begin
                    w_gnt0 = ~r_last;
                    w_gnt1 = r_last;
                end else begin
                    w_gnt0 = r_last;
                    w_gnt1 = ~r_last;
                end
            end
        end
    end

    // Memory forwarding: the granted command goes out, otherwise all zero
    always_comb begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt0) begin
            w_mem_read  = ~bus.we0;
            w_mem_write = bus.we0;
            w_mem_addr  = bus.addr0;
            w_mem_wdata = bus.wdata0;
        end else if (w_gnt1) begin
            w_mem_read  = ~bus.we1;
            w_mem_write = bus.we1;
            w_mem_addr  = bus.addr1;
            w_mem_wdata = bus.wdata1;
        end
    end

    // Read return: capture memory data on a granted read, strobe one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
            if (w_gnt0 && !bus.we0) begin
                r_rdata0 <= bus.mem_rdata;
            end
            if (w_gnt1 && !bus.we1) begin
                r_rdata1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.gnt0          = w_gnt0;
    assign bus.gnt1          = w_gnt1;
    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.mem_addr      = w_mem_addr;
    assign bus.mem_wdata     = w_mem_wdata;
    assign bus.rvalid0       = r_rvalid0;
    assign bus.rvalid1       = r_rvalid1;
    assign bus.rdata0        = r_rdata0;
    assign bus.rdata1        = r_rdata1;
    assign bus.dbg_last      = r_last;
    assign bus.dbg_busy_prev = r_busy_prev;
    assign bus.dbg_run_len   = r_run_len;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small data_memory model and
// per-port expected read queues.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) bus();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // data_memory model: combinational read, write at the rising edge
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    // Scoreboard: every rvalid pops the oldest expected read for that port
    always @(negedge clk) begin
        if (bus.rvalid0) begin
            n_checks++;
            if (exp_q0.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid0_unexpected: got rdata0=%h, required no rvalid0", bus.rdata0);
            end else begin
                logic [DW-1:0] e;
                e = exp_q0.pop_front();
                if (bus.rdata0 !== e) begin
                    n_fail++;
                    $display("FAIL rdata0_sb: got %h, required %h", bus.rdata0, e);
                end
            end
        end
        if (bus.rvalid1) begin
            n_checks++;
            if (exp_q1.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid1_unexpected: got rdata1=%h, required no rvalid1", bus.rdata1);
            end else begin
                logic [DW-1:0] e;
                e = exp_q1.pop_front();
                if (bus.rdata1 !== e) begin
                    n_fail++;
                    $display("FAIL rdata1_sb: got %h, required %h", bus.rdata1, e);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.we0  = 1'b1; bus.we1  = 1'b1;
        bus.addr0 = 32'd7; bus.addr1 = 32'd8;
        bus.wdata0 = 32'h1111_1111; bus.wdata1 = 32'h2222_2222;
        repeat (3) begin
            tick(); #2;
            n_checks++;
            if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
                n_fail++; $display("FAIL reset_gnt: got %b%b, required 00", bus.gnt0, bus.gnt1);
            end
            n_checks++;
            if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
                n_fail++; $display("FAIL reset_mem: got w=%b r=%b a=%h d=%h, required all 0",
                                   bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
            end
            n_checks++;
            if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0 || bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
                n_fail++; $display("FAIL reset_rd: got v=%b%b d0=%h d1=%h, required all 0",
                                   bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1);
            end
        end
        // First tie after reset goes to port 0
        tick();
        rst = 1'b1;
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = 32'd1; bus.addr1 = 32'd2;
        #2;
        n_checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL first_tie: got gnt=%b%b, required 10", bus.gnt0, bus.gnt1);
        end
        n_checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'd1) begin
            n_fail++; $display("FAIL first_tie_mem: got r=%b a=%h, required r=1 a=1", bus.mem_read, bus.mem_addr);
        end
        exp_q0.push_back(ref_mem[1]);
        tick(); idle(); #2;
    endtask

    task automatic test_single_port();
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'd5; bus.wdata0 = 32'hDEAD_BEEF;
        #2;
        n_checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
            n_fail++; $display("FAIL sp_write_gnt: got gnt=%b%b w=%b r=%b, required 10 w=1 r=0",
                               bus.gnt0, bus.gnt1, bus.mem_write, bus.mem_read);
        end
        n_checks++;
        if (bus.mem_addr !== 32'd5 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sp_write_bus: got a=%h d=%h, required 5 deadbeef", bus.mem_addr, bus.mem_wdata);
        end
        ref_mem[5] = 32'hDEAD_BEEF;
        tick();
        bus.we0 = 1'b0;
        #2;
        n_checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin
            n_fail++; $display("FAIL sp_read_gnt: got gnt=%b%b r=%b w=%b, required 10 r=1 w=0",
                               bus.gnt0, bus.gnt1, bus.mem_read, bus.mem_write);
        end
        exp_q0.push_back(ref_mem[5]);
        tick();
        idle();
        #2;
        n_checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sp_rvalid: got v=%b d=%h, required 1 deadbeef", bus.rvalid0, bus.rdata0);
        end
        n_checks++;
        if (bus.gnt0 !== 1'b0 || bus.mem_addr !== '0 || bus.mem_read !== 1'b0) begin
            n_fail++; $display("FAIL sp_idle_bus: got gnt0=%b a=%h r=%b, required 0 0 0", bus.gnt0, bus.mem_addr, bus.mem_read);
        end
        tick(); #2;
        n_checks++;
        if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sp_hold: got v=%b d=%h, required 0 deadbeef", bus.rvalid0, bus.rdata0);
        end
    endtask

    // Last winner is port 0 and the bus was idle, so the first tie goes to 1
    task automatic test_contention();
        int wait0;
        int wait1;
        logic exp_port;
        wait0 = 0;
        wait1 = 0;
        tick();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 32'd20; bus.addr1 = 32'd21;
        for (int k = 0; k < 12; k++) begin
            #2;
            exp_port = ((k / MB) % 2 == 0) ? 1'b1 : 1'b0;
            n_checks++;
            if (bus.gnt0 !== ~exp_port || bus.gnt1 !== exp_port) begin
                n_fail++; $display("FAIL contention_k%0d: got gnt=%b%b, required port %0d", k, bus.gnt0, bus.gnt1, exp_port);
            end
            if (exp_port) begin
                exp_q1.push_back(ref_mem[21]);
                wait0++; wait1 = 0;
            end else begin
                exp_q0.push_back(ref_mem[20]);
                wait1++; wait0 = 0;
            end
            n_checks++;
            if (wait0 > MB || wait1 > MB) begin
                n_fail++; $display("FAIL starvation: got waits %0d/%0d, required <= %0d", wait0, wait1, MB);
            end
            tick();
        end
        idle();
        #2;
    endtask

    // Port 0 wins twice, one idle cycle, then a tie must go to port 1
    task automatic test_idle_gap();
        tick();
        bus.req0 = 1'b1; bus.addr0 = 32'd22;
        #2;
        n_checks++;
        if (bus.gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL gap_g0a: got gnt0=%b, required 1", bus.gnt0);
        end
        exp_q0.push_back(ref_mem[22]);
        tick(); #2;
        n_checks++;
        if (bus.gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL gap_g0b: got gnt0=%b, required 1", bus.gnt0);
        end
        exp_q0.push_back(ref_mem[22]);
        tick();
        idle();
        #2;
        tick();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 32'd22; bus.addr1 = 32'd23;
        #2;
        n_checks++;
        if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
            n_fail++; $display("FAIL gap_tie: got gnt=%b%b, required 01", bus.gnt0, bus.gnt1);
        end
        exp_q1.push_back(ref_mem[23]);
        tick();
        bus.req1 = 1'b0;
        #2;
        n_checks++;
        if (bus.dbg_run_len !== 3'd1 || bus.dbg_last !== 1'b1) begin
            n_fail++; $display("FAIL gap_runlen: got run=%0d last=%b, required 1 1", bus.dbg_run_len, bus.dbg_last);
        end
        n_checks++;
        if (bus.gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL gap_g0c: got gnt0=%b, required 1", bus.gnt0);
        end
        exp_q0.push_back(ref_mem[22]);
        tick();
        idle();
        #2;
    endtask

    task automatic test_cross_port();
        tick();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'd9; bus.wdata1 = 32'h1234_5678;
        #2;
        n_checks++;
        if (bus.gnt1 !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_wdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL xp_write: got g1=%b w=%b d=%h, required 1 1 12345678",
                               bus.gnt1, bus.mem_write, bus.mem_wdata);
        end
        ref_mem[9] = 32'h1234_5678;
        tick();
        idle();
        bus.req0 = 1'b1; bus.addr0 = 32'd9;
        #2;
        n_checks++;
        if (bus.gnt0 !== 1'b1 || bus.mem_read !== 1'b1) begin
            n_fail++; $display("FAIL xp_read: got g0=%b r=%b, required 1 1", bus.gnt0, bus.mem_read);
        end
        exp_q0.push_back(ref_mem[9]);
        tick();
        idle();
        #2;
        n_checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h1234_5678 || bus.rvalid1 !== 1'b0) begin
            n_fail++; $display("FAIL xp_return: got v0=%b d0=%h v1=%b, required 1 12345678 0",
                               bus.rvalid0, bus.rdata0, bus.rvalid1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.req0 = 1'b1; bus.we0 = 1'b1;
            bus.addr0 = AW'(40 + i);
            bus.wdata0 = $urandom;
            ref_mem[40 + i] = bus.wdata0;
            #2;
            n_checks++;
            if (bus.gnt0 !== 1'b1 || bus.mem_write !== 1'b1) begin
                n_fail++; $display("FAIL b2b_write%0d: got g0=%b w=%b, required 1 1", i, bus.gnt0, bus.mem_write);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            idle();
            bus.req1 = 1'b1;
            bus.addr1 = AW'(40 + i);
            #2;
            n_checks++;
            if (bus.gnt1 !== 1'b1) begin
                n_fail++; $display("FAIL b2b_gnt%0d: got g1=%b, required 1", i, bus.gnt1);
            end
            if (i > 0) begin
                n_checks++;
                if (bus.rvalid1 !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_rvalid%0d: got %b, required 1", i, bus.rvalid1);
                end
            end
            exp_q1.push_back(ref_mem[40 + i]);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (bus.rvalid1 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_rvalid_last: got %b, required 1", bus.rvalid1);
        end
        tick(); #2;
        n_checks++;
        if (bus.rvalid1 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_rvalid_end: got %b, required 0", bus.rvalid1);
        end
    endtask

    task automatic test_reset_mid_read();
        tick();
        bus.req1 = 1'b1; bus.addr1 = 32'd3;
        #2;
        n_checks++;
        if (bus.gnt1 !== 1'b1) begin
            n_fail++; $display("FAIL mr_gnt: got g1=%b, required 1", bus.gnt1);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.gnt1 !== 1'b0 || bus.mem_read !== 1'b0) begin
            n_fail++; $display("FAIL mr_forced: got g1=%b r=%b, required 0 0", bus.gnt1, bus.mem_read);
        end
        tick();
        idle();
        #2;
        n_checks++;
        if (bus.rvalid1 !== 1'b0 || bus.rdata1 !== '0 || bus.rdata0 !== '0) begin
            n_fail++; $display("FAIL mr_return: got v1=%b d1=%h d0=%h, required 0 0 0",
                               bus.rvalid1, bus.rdata1, bus.rdata0);
        end
        tick();
        rst = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 32'd4; bus.addr1 = 32'd6;
        #2;
        n_checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL mr_tie: got gnt=%b%b, required 10", bus.gnt0, bus.gnt1);
        end
        exp_q0.push_back(ref_mem[4]);
        tick();
        idle();
        #2;
    endtask

    // Test sequence and final report
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        idle();
        rst = 1'b0;
        test_reset();
        test_single_port();
        test_contention();
        test_idle_gap();
        test_cross_port();
        test_back_to_back();
        test_reset_mid_read();
        repeat (3) tick();
        n_checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d/%0d reads outstanding, required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
